// File: rtl/i3c_cpuif_pkg.sv
// Shared types for the I3C CPUIF request/response slice.
package i3c_cpuif_pkg;

  localparam int unsigned CPUIF_ADDR_W = 12;
  localparam int unsigned CPUIF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } cpuif_state_e;

  typedef struct packed {
    logic                    is_wr;
    logic [CPUIF_ADDR_W-1:0] addr;
    logic [CPUIF_DATA_W-1:0] wr_data;
    logic [CPUIF_DATA_W-1:0] wr_biten;
  } cpuif_req_t;

  typedef struct packed {
    logic                    err;
    logic [CPUIF_DATA_W-1:0] rd_data;
  } cpuif_rsp_t;

endpackage

// File: rtl/i3c_cpuif_timeout.sv
// Saturating down-counter that flags an access that has waited too long.
// A TIMEOUT_CYCLES of 0 never expires.
module i3c_cpuif_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expired_c
);

  localparam int unsigned LOAD_VAL = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(LOAD_VAL);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Reaching zero during the wait is the last cycle an ack may still arrive.
  assign expired_c = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == '0);

endmodule

// File: rtl/i3c_cpuif_slice.sv
// Registered CPUIF slice between the AHB adapter and the I3C CSR block:
// one outstanding access, registered stall/ack, forced error on timeout.
module i3c_cpuif_slice
  import i3c_cpuif_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  hclk_i,
  input  logic                  hreset_n_i,
  input  logic                  s_cpuif_req,
  input  logic                  s_cpuif_req_is_wr,
  input  logic [ADDR_WIDTH-1:0] s_cpuif_addr,
  input  logic [DATA_WIDTH-1:0] s_cpuif_wr_data,
  input  logic [DATA_WIDTH-1:0] s_cpuif_wr_biten,
  output logic                  s_cpuif_req_stall_wr,
  output logic                  s_cpuif_req_stall_rd,
  output logic                  s_cpuif_rd_ack,
  output logic                  s_cpuif_rd_err,
  output logic [DATA_WIDTH-1:0] s_cpuif_rd_data,
  output logic                  s_cpuif_wr_ack,
  output logic                  s_cpuif_wr_err,
  output logic                  m_cpuif_req,
  output logic                  m_cpuif_req_is_wr,
  output logic [ADDR_WIDTH-1:0] m_cpuif_addr,
  output logic [DATA_WIDTH-1:0] m_cpuif_wr_data,
  output logic [DATA_WIDTH-1:0] m_cpuif_wr_biten,
  input  logic                  m_cpuif_req_stall_wr,
  input  logic                  m_cpuif_req_stall_rd,
  input  logic                  m_cpuif_rd_ack,
  input  logic                  m_cpuif_rd_err,
  input  logic [DATA_WIDTH-1:0] m_cpuif_rd_data,
  input  logic                  m_cpuif_wr_ack,
  input  logic                  m_cpuif_wr_err
);

  localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

  cpuif_state_e state_q, state_d;
  cpuif_req_t   req_q, req_d;
  cpuif_rsp_t   rsp_q, rsp_d;
  logic         m_req_q, m_req_d;
  logic         stall_q, stall_d;
  logic         rd_ack_q, rd_ack_d;
  logic         wr_ack_q, wr_ack_d;
  logic         rd_err_q, rd_err_d;
  logic         wr_err_q, wr_err_d;

  logic                  tmo_load;
  logic                  tmo_en;
  logic                  tmo_expired_c;
  logic                  ds_stall;
  logic                  ds_ack;
  logic                  ds_err;
  logic [DATA_WIDTH-1:0] ds_rdata;

  i3c_cpuif_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clk       (hclk_i),
    .rst_n     (hreset_n_i),
    .load_i    (tmo_load),
    .en_i      (tmo_en),
    .expired_c (tmo_expired_c)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    rsp_d    = rsp_q;
    tmo_load = 1'b0;
    tmo_en   = 1'b0;

    // Only the downstream signals matching the captured access type count.
    ds_stall = req_q.is_wr ? m_cpuif_req_stall_wr : m_cpuif_req_stall_rd;
    ds_ack   = req_q.is_wr ? m_cpuif_wr_ack       : m_cpuif_rd_ack;
    ds_err   = req_q.is_wr ? m_cpuif_wr_err       : m_cpuif_rd_err;
    ds_rdata = req_q.is_wr ? '0                   : m_cpuif_rd_data;

    case (state_q)
      IDLE: begin
        rsp_d = '0;
        if (s_cpuif_req) begin
          req_d.is_wr    = s_cpuif_req_is_wr;
          req_d.addr     = CPUIF_ADDR_W'(s_cpuif_addr);
          req_d.wr_data  = s_cpuif_req_is_wr ? CPUIF_DATA_W'(s_cpuif_wr_data)  : '0;
          req_d.wr_biten = s_cpuif_req_is_wr ? CPUIF_DATA_W'(s_cpuif_wr_biten) : '0;
          tmo_load       = 1'b1;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        if (!ds_stall) begin
          if (ds_ack) begin
            rsp_d.err     = ds_err;
            rsp_d.rd_data = CPUIF_DATA_W'(ds_rdata);
            state_d       = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        tmo_en = 1'b1;
        if (ds_ack) begin
          rsp_d.err     = ds_err;
          rsp_d.rd_data = CPUIF_DATA_W'(ds_rdata);
          state_d       = RESP;
        end else if (tmo_expired_c) begin
          rsp_d.err     = 1'b1;
          rsp_d.rd_data = '0;
          state_d       = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs follow the next state so they are valid from the edge of entry.
    m_req_d  = (state_d == ISSUE);
    stall_d  = (state_d != IDLE);
    rd_ack_d = (state_d == RESP) && !req_d.is_wr;
    wr_ack_d = (state_d == RESP) &&  req_d.is_wr;
    rd_err_d = rd_ack_d && rsp_d.err;
    wr_err_d = wr_ack_d && rsp_d.err;
  end

  always_ff @(posedge hclk_i or negedge hreset_n_i) begin
    if (!hreset_n_i) begin
      state_q  <= IDLE;
      req_q    <= '0;
      rsp_q    <= '0;
      m_req_q  <= 1'b0;
      stall_q  <= 1'b0;
      rd_ack_q <= 1'b0;
      wr_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      rsp_q    <= rsp_d;
      m_req_q  <= m_req_d;
      stall_q  <= stall_d;
      rd_ack_q <= rd_ack_d;
      wr_ack_q <= wr_ack_d;
      rd_err_q <= rd_err_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign s_cpuif_req_stall_wr = stall_q;
  assign s_cpuif_req_stall_rd = stall_q;
  assign s_cpuif_rd_ack       = rd_ack_q;
  assign s_cpuif_rd_err       = rd_err_q;
  assign s_cpuif_rd_data      = DATA_WIDTH'(rsp_q.rd_data);
  assign s_cpuif_wr_ack       = wr_ack_q;
  assign s_cpuif_wr_err       = wr_err_q;
  assign m_cpuif_req          = m_req_q;
  assign m_cpuif_req_is_wr    = req_q.is_wr;
  assign m_cpuif_addr         = ADDR_WIDTH'(req_q.addr);
  assign m_cpuif_wr_data      = DATA_WIDTH'(req_q.wr_data);
  assign m_cpuif_wr_biten     = DATA_WIDTH'(req_q.wr_biten);

endmodule

// File: tb/tb_i3c_cpuif_slice.sv
// Scoreboard bench for i3c_cpuif_slice: directed accesses push expected
// responses, a negedge monitor pops and compares upstream acks.
module tb_i3c_cpuif_slice;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          clk;
  logic          rst_n;
  logic          s_req, s_is_wr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_biten;
  logic          s_stall_wr, s_stall_rd;
  logic          s_rd_ack, s_rd_err, s_wr_ack, s_wr_err;
  logic [DW-1:0] s_rdata;
  logic          m_req, m_is_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_biten;
  logic          m_stall_wr, m_stall_rd;
  logic          m_rd_ack, m_rd_err, m_wr_ack, m_wr_err;
  logic [DW-1:0] m_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic          wr;
    logic          err;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  i3c_cpuif_slice #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .hclk_i               (clk),
    .hreset_n_i           (rst_n),
    .s_cpuif_req          (s_req),
    .s_cpuif_req_is_wr    (s_is_wr),
    .s_cpuif_addr         (s_addr),
    .s_cpuif_wr_data      (s_wdata),
    .s_cpuif_wr_biten     (s_biten),
    .s_cpuif_req_stall_wr (s_stall_wr),
    .s_cpuif_req_stall_rd (s_stall_rd),
    .s_cpuif_rd_ack       (s_rd_ack),
    .s_cpuif_rd_err       (s_rd_err),
    .s_cpuif_rd_data      (s_rdata),
    .s_cpuif_wr_ack       (s_wr_ack),
    .s_cpuif_wr_err       (s_wr_err),
    .m_cpuif_req          (m_req),
    .m_cpuif_req_is_wr    (m_is_wr),
    .m_cpuif_addr         (m_addr),
    .m_cpuif_wr_data      (m_wdata),
    .m_cpuif_wr_biten     (m_biten),
    .m_cpuif_req_stall_wr (m_stall_wr),
    .m_cpuif_req_stall_rd (m_stall_rd),
    .m_cpuif_rd_ack       (m_rd_ack),
    .m_cpuif_rd_err       (m_rd_err),
    .m_cpuif_rd_data      (m_rdata),
    .m_cpuif_wr_ack       (m_wr_ack),
    .m_cpuif_wr_err       (m_wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every upstream ack must match the oldest expected response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_rd_ack && s_wr_ack) chk("dual_ack", 1'b1, 1'b0);
      if (s_rd_ack || s_wr_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 1'b1, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ack_type", s_wr_ack, mon_e.wr);
          chk("ack_err", mon_e.wr ? s_wr_err : s_rd_err, mon_e.err);
          chk("ack_rd_data", s_rdata, mon_e.data);
          chk("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end
      if (m_req && !m_is_wr) chk("rd_wr_data_zero", m_wdata, '0);
    end
  end

  task automatic ds_clear();
    m_stall_wr = 1'b0; m_stall_rd = 1'b0;
    m_rd_ack   = 1'b0; m_rd_err   = 1'b0; m_rdata = '0;
    m_wr_ack   = 1'b0; m_wr_err   = 1'b0;
  endtask

  task automatic ds_ack(input logic wr, input logic err, input logic [DW-1:0] rd);
    if (wr) begin
      m_wr_ack = 1'b1; m_wr_err = err;
    end else begin
      m_rd_ack = 1'b1; m_rd_err = err; m_rdata = rd;
    end
  endtask

  // wait_n < 0: downstream never acks (timeout), then a late ack is injected.
  // noise: wrong-type ack with err asserted on every WAIT cycle.
  task automatic access(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] bi, input int stall_n, input int wait_n,
                        input logic err, input logic [DW-1:0] rd, input bit noise);
    exp_t e;
    bit   seen;
    @(negedge clk);
    ds_clear();
    s_req = 1'b1; s_is_wr = wr; s_addr = a; s_wdata = wd; s_biten = bi;
    e.wr   = wr;
    e.err  = (wait_n < 0) ? 1'b1 : err;
    e.data = (wr || wait_n < 0) ? '0 : rd;
    e.cyc  = cyc + 2 + stall_n + ((wait_n < 0) ? int'(TO) : wait_n);
    exp_q.push_back(e);
    for (int k = 0; k <= stall_n; k++) begin
      @(negedge clk);
      ds_clear();
      chk("m_req_issue", m_req, 1'b1);
      chk("m_is_wr", m_is_wr, wr);
      chk("m_addr", m_addr, a);
      chk("m_wr_data", m_wdata, wr ? wd : '0);
      chk("m_wr_biten", m_biten, wr ? bi : '0);
      if (k == 0) begin
        chk("s_stall_wr_busy", s_stall_wr, 1'b1);
        chk("s_stall_rd_busy", s_stall_rd, 1'b1);
      end
      m_stall_wr = (k < stall_n);
      m_stall_rd = (k < stall_n);
      if (k == stall_n && wait_n == 0) ds_ack(wr, err, rd);
    end
    for (int k = 1; k <= wait_n; k++) begin
      @(negedge clk);
      ds_clear();
      chk("m_req_wait", m_req, 1'b0);
      if (noise) begin
        if (wr) begin m_rd_ack = 1'b1; m_rd_err = 1'b1; m_rdata = 32'hBAAD_BAAD; end
        else    begin m_wr_ack = 1'b1; m_wr_err = 1'b1; end
      end
      if (k == wait_n) ds_ack(wr, err, rd);
    end
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      ds_clear();
      if (s_rd_ack || s_wr_ack) seen = 1'b1;
    end
    s_req = 1'b0;
    if (!seen) chk("resp_timeout", 1'b0, 1'b1);
    if (wait_n < 0) begin
      repeat (3) @(negedge clk);
      m_rd_ack = 1'b1; m_rd_err = 1'b1; m_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      ds_clear();
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s_req = 1'b0; s_is_wr = 1'b0; s_addr = '0; s_wdata = '0; s_biten = '0;
    ds_clear();
    repeat (2) @(negedge clk);
    chk("rst_m_req", m_req, 1'b0);
    chk("rst_m_addr", m_addr, '0);
    chk("rst_stalls", {s_stall_wr, s_stall_rd}, 2'b00);
    chk("rst_acks", {s_rd_ack, s_wr_ack, s_rd_err, s_wr_err}, 4'b0000);
    chk("rst_rd_data", s_rdata, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_stalls", {s_stall_wr, s_stall_rd}, 2'b00);

    access(1'b0, 12'h010, 32'h0, 32'h0, 0, 0, 1'b0, 32'hA5A5_0001, 1'b0);
    access(1'b1, 12'h104, 32'h0000_00FF, 32'hFFFF_FFFF, 3, 0, 1'b0, 32'h0, 1'b0);
    access(1'b0, 12'h200, 32'h0, 32'h0, 0, 3, 1'b1, 32'h1234_5678, 1'b1);
    access(1'b0, 12'h300, 32'h0, 32'h0, 0, -1, 1'b0, 32'h0, 1'b0);
    access(1'b1, 12'h040, 32'hCAFE_F00D, 32'h0000_FFFF, 0, 1, 1'b0, 32'h0, 1'b0);
    access(1'b0, 12'h044, 32'h1111_1111, 32'hFFFF_FFFF, 0, 1, 1'b0, 32'h0BAD_C0DE, 1'b0);
    access(1'b1, 12'h108, 32'h0000_0005, 32'h0000_000F, 1, 2, 1'b1, 32'h0, 1'b1);

    // Reset while the access sits in WAIT: everything drops, nothing replays.
    @(negedge clk);
    s_req = 1'b1; s_is_wr = 1'b0; s_addr = 12'h020; s_wdata = '0; s_biten = '0;
    repeat (3) @(negedge clk);
    chk("pre_rst_stall", s_stall_rd, 1'b1);
    s_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_req", m_req, 1'b0);
    chk("mid_rst_m_addr", m_addr, '0);
    chk("mid_rst_stalls", {s_stall_wr, s_stall_rd}, 2'b00);
    chk("mid_rst_acks", {s_rd_ack, s_wr_ack}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_m_req", m_req, 1'b0);
    access(1'b0, 12'h020, 32'h0, 32'h0, 0, 0, 1'b0, 32'h7777_0007, 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
